ghost_ctrl: RTL



---
 rtl/ghost_pkg.sv | 38 +++
 rtl/ghost_dir_select.sv | 71 +++++++
 rtl/pacman_wall_collision.sv | 14 +
 rtl/ghost_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ghost_pkg.sv
// Shared types and helpers for the ghost motion controller.
// Direction encoding matches the Ghost_Dir output: 0 up, 1 down, 2 left, 3 right.
package ghost_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        DOWN  = 2'd1,
        LEFT  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        CAGED   = 2'd0,
        EXIT    = 2'd1,
        SCATTER = 2'd2,
        CHASE   = 2'd3
    } mode_t;

    localparam logic [9:0] TUNNEL_LO = 10'd120;
    localparam logic [9:0] TUNNEL_HI = 10'd520;

    function automatic dir_t reverse(input dir_t d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            LEFT:    return RIGHT;
            default: return LEFT;
        endcase
    endfunction

    // Magnitude of an 11-bit two's-complement difference.
    function automatic logic [10:0] abs_diff11(input logic [10:0] a, input logic [10:0] b);
        logic [10:0] d;
        d = a - b;
        return d[10] ? (11'd0 - d) : d;
    endfunction

endpackage

// File: rtl/ghost_dir_select.sv
// Picks the heading whose next position is closest (Manhattan) to the target,
// never reversing unless that is the only way out.
module ghost_dir_select
    import ghost_pkg::*;
(
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [9:0] tgt_x,
    input  logic [9:0] tgt_y,
    input  dir_t       heading,
    input  logic [3:0] blocked,
    output dir_t       choice,
    output logic       hold
);

    // Candidate order doubles as the tie-break priority.
    function automatic dir_t prio_dir(input logic [1:0] i);
        case (i)
            2'd0:    return UP;
            2'd1:    return LEFT;
            2'd2:    return DOWN;
            default: return RIGHT;
        endcase
    endfunction

    dir_t        cand;
    dir_t        back;
    logic        found;
    logic [10:0] best;
    logic [10:0] nx;
    logic [10:0] ny;
    logic [10:0] cost;

    always_comb begin
        choice = heading;
        hold   = 1'b0;
        found  = 1'b0;
        best   = '1;
        cand   = UP;
        nx     = '0;
        ny     = '0;
        cost   = '0;
        back   = reverse(heading);
        for (int unsigned i = 0; i < 4; i++) begin
            cand = prio_dir(2'(i));
            nx   = {1'b0, pos_x};
            ny   = {1'b0, pos_y};
            case (cand)
                UP:      ny = ny - 11'd1;
                DOWN:    ny = ny + 11'd1;
                LEFT:    nx = nx - 11'd1;
                default: nx = nx + 11'd1;
            endcase
            cost = abs_diff11(nx, {1'b0, tgt_x}) + abs_diff11(ny, {1'b0, tgt_y});
            if (!blocked[cand] && (cand != back) && (!found || (cost < best))) begin
                found  = 1'b1;
                best   = cost;
                choice = cand;
            end
        end
        if (!found) begin
            if (!blocked[back]) begin
                choice = back;
            end else begin
                choice = heading;
                hold   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pacman_wall_collision.sv
// Maze wall lookup: reports whether a probe point lies inside a wall.
// Map: top and bottom borders plus one central pillar.
module pacman_wall_collision (
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       is_wall
);

    always_comb begin
        is_wall = (y < 10'd16) || (y > 10'd463) ||
                  ((x >= 10'd400) && (x < 10'd416) && (y >= 10'd120) && (y < 10'd360));
    end

endmodule

// File: rtl/ghost_ctrl.sv
// Autonomous ghost: cage / exit / scatter / chase mode machine with wall-probed
// steering, tunnel wrap and player capture. One step per enabled frame.
module ghost_ctrl
    import ghost_pkg::*;
#(
    parameter int unsigned START_X        = 320,
    parameter int unsigned START_Y        = 240,
    parameter int unsigned EXIT_Y         = 210,
    parameter int unsigned RELEASE_FRAMES = 120,
    parameter int unsigned SCATTER_FRAMES = 240,
    parameter int unsigned CHASE_FRAMES   = 600,
    parameter int unsigned SCATTER_X      = 520,
    parameter int unsigned SCATTER_Y      = 0,
    parameter int unsigned GHOST_SIZE     = 8
) (
    input  logic       frame_clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [9:0] PacX,
    input  logic [9:0] PacY,
    output logic [9:0] GhostX,
    output logic [9:0] GhostY,
    output logic [9:0] GhostS,
    output logic [1:0] Ghost_Dir,
    output logic [1:0] Mode,
    output logic       Caught
);

    localparam logic [9:0]  SX         = 10'(START_X);
    localparam logic [9:0]  SY         = 10'(START_Y);
    localparam logic [9:0]  EY         = 10'(EXIT_Y);
    localparam logic [9:0]  SIZE       = 10'(GHOST_SIZE);
    localparam logic [9:0]  TX_SCAT    = 10'(SCATTER_X);
    localparam logic [9:0]  TY_SCAT    = 10'(SCATTER_Y);
    localparam logic [9:0]  REL_LAST   = 10'(RELEASE_FRAMES - 1);
    localparam logic [9:0]  SCAT_LAST  = 10'(SCATTER_FRAMES - 1);
    localparam logic [9:0]  CHASE_LAST = 10'(CHASE_FRAMES - 1);
    localparam logic [10:0] CATCH_DIST = 11'(2 * GHOST_SIZE);

    mode_t      mode, mode_n;
    dir_t       dir, dir_n;
    logic [9:0] timer, timer_n;
    logic [9:0] x, x_n;
    logic [9:0] y, y_n;
    logic       caught, caught_n;

    logic [3:0] blocked;
    logic [9:0] probe_up_y, probe_dn_y, probe_lt_x, probe_rt_x;
    logic [9:0] tgt_x, tgt_y;
    dir_t       sel_dir;
    logic       sel_hold;
    logic       capture;
    logic       phase_last;
    logic [9:0] y_up;
    dir_t       move_dir;
    logic       do_move;

    assign probe_up_y = y - SIZE;
    assign probe_dn_y = y + SIZE;
    assign probe_lt_x = x - SIZE;
    assign probe_rt_x = x + SIZE;

    pacman_wall_collision probe_up (.x(x),          .y(probe_up_y), .is_wall(blocked[0]));
    pacman_wall_collision probe_dn (.x(x),          .y(probe_dn_y), .is_wall(blocked[1]));
    pacman_wall_collision probe_lt (.x(probe_lt_x), .y(y),          .is_wall(blocked[2]));
    pacman_wall_collision probe_rt (.x(probe_rt_x), .y(y),          .is_wall(blocked[3]));

    assign tgt_x = (mode == SCATTER) ? TX_SCAT : PacX;
    assign tgt_y = (mode == SCATTER) ? TY_SCAT : PacY;

    ghost_dir_select u_select (
        .pos_x   (x),
        .pos_y   (y),
        .tgt_x   (tgt_x),
        .tgt_y   (tgt_y),
        .heading (dir),
        .blocked (blocked),
        .choice  (sel_dir),
        .hold    (sel_hold)
    );

    assign capture = (abs_diff11({1'b0, PacX}, {1'b0, x}) < CATCH_DIST) &&
                     (abs_diff11({1'b0, PacY}, {1'b0, y}) < CATCH_DIST);
    assign phase_last = (mode == SCATTER) ? (timer == SCAT_LAST) : (timer == CHASE_LAST);
    assign y_up = y - 10'd1;

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            mode   <= CAGED;
            dir    <= UP;
            timer  <= '0;
            x      <= SX;
            y      <= SY;
            caught <= 1'b0;
        end else begin
            mode   <= mode_n;
            dir    <= dir_n;
            timer  <= timer_n;
            x      <= x_n;
            y      <= y_n;
            caught <= caught_n;
        end
    end

    always_comb begin
        mode_n   = mode;
        dir_n    = dir;
        timer_n  = timer;
        x_n      = x;
        y_n      = y;
        caught_n = 1'b0;
        move_dir = dir;
        do_move  = 1'b0;
        if (Enable) begin
            unique case (mode)
                CAGED: begin
                    if (timer == REL_LAST) begin
                        mode_n  = EXIT;
                        timer_n = '0;
                    end else begin
                        timer_n = timer + 10'd1;
                    end
                end
                EXIT: begin
                    if (x < SX) begin
                        x_n = x + 10'd1;
                    end else if (x > SX) begin
                        x_n = x - 10'd1;
                    end else begin
                        y_n = y_up;
                        if (y_up <= EY) begin
                            mode_n  = SCATTER;
                            timer_n = '0;
                            dir_n   = LEFT;
                        end
                    end
                end
                default: begin
                    if (capture) begin
                        caught_n = 1'b1;
                        mode_n   = CAGED;
                        timer_n  = '0;
                        dir_n    = UP;
                        x_n      = SX;
                        y_n      = SY;
                    end else begin
                        if (phase_last) begin
                            mode_n  = (mode == SCATTER) ? CHASE : SCATTER;
                            timer_n = '0;
                        end else begin
                            timer_n = timer + 10'd1;
                        end
                        // Phase change forces a reversal, but only if that way is open.
                        if (phase_last && !blocked[reverse(dir)]) begin
                            move_dir = reverse(dir);
                            do_move  = 1'b1;
                        end else if (!sel_hold) begin
                            move_dir = sel_dir;
                            do_move  = 1'b1;
                        end
                        if (do_move) begin
                            dir_n = move_dir;
                            case (move_dir)
                                UP:      y_n = y - 10'd1;
                                DOWN:    y_n = y + 10'd1;
                                LEFT:    x_n = x - 10'd1;
                                default: x_n = x + 10'd1;
                            endcase
                        end
                        if (x < TUNNEL_LO) begin
                            x_n = TUNNEL_HI;
                        end else if (x > TUNNEL_HI) begin
                            x_n = TUNNEL_LO;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        GhostX    = x;
        GhostY    = y;
        GhostS    = SIZE;
        Ghost_Dir = dir;
        Mode      = mode;
        Caught    = caught;
    end

endmodule
